// File: rtl/display_mux_ctrl.sv
// Dual seven-segment time-multiplexing controller: one-hot digit/blank sequencer
// driving the encoder select and the two active-low anodes.
module display_mux_ctrl #(
    parameter int CLK_DIV      = 24000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic blank_n,
    output logic sel,
    output logic an1_n,
    output logic an2_n,
    output logic digit_done
);

    localparam int M1 = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
    localparam int M2 = (M1 > 2) ? M1 : 2;
    localparam int CW = $clog2(M2);

    localparam logic [CW-1:0] DIG_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] BLK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic          NO_GAP   = (BLANK_CYCLES == 0);

    typedef enum logic [3:0] {
        S_DIG1    = 4'b0001,
        S_BLANK_A = 4'b0010,
        S_DIG2    = 4'b0100,
        S_BLANK_B = 4'b1000
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_BLANK_B;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // With no gap configured the blank states are passed through in zero time
    always_comb begin
        state_d = state_q;
        count_d = count_q + 1'b1;
        case (state_q)
            S_DIG1: if (count_q == DIG_LAST) begin
                state_d = NO_GAP ? S_DIG2 : S_BLANK_A;
                count_d = '0;
            end
            S_BLANK_A: if (NO_GAP || count_q == BLK_LAST) begin
                state_d = S_DIG2;
                count_d = '0;
            end
            S_DIG2: if (count_q == DIG_LAST) begin
                state_d = NO_GAP ? S_DIG1 : S_BLANK_B;
                count_d = '0;
            end
            S_BLANK_B: if (NO_GAP || count_q == BLK_LAST) begin
                state_d = S_DIG1;
                count_d = '0;
            end
            default: begin
                state_d = S_BLANK_B;
                count_d = '0;
            end
        endcase
    end

    logic dig1, dig2;
    assign dig1 = (state_q == S_DIG1);
    assign dig2 = (state_q == S_DIG2);

    // sel leads the anode: it flips on blank entry so the encoder settles early
    assign sel        = (state_q == S_BLANK_A) || dig2;
    assign an1_n      = ~(dig1 & blank_n);
    assign an2_n      = ~(dig2 & blank_n);
    assign digit_done = (dig1 || dig2) && (count_q == DIG_LAST);

endmodule
